// File: rtl/pmp_csr_regs.sv
// PMP CSR bank: decodes pmpcfg*/pmpaddr* accesses, applies lock, TOR-lock and WARL
// legalisation per entry, and exports the stored values to the PMP address checkers.

module pmp_entry #(
  parameter int PA_BITS = 56,
  parameter int G       = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cfg_we,
  input  logic [7:0]         cfg_wdata,
  input  logic               adr_we,
  input  logic [PA_BITS-3:0] adr_wdata,
  input  logic               next_tor_lock,
  output logic [7:0]         cfg,
  output logic [PA_BITS-3:0] adr,
  output logic [PA_BITS-3:0] adr_rd
);
  localparam int AW = PA_BITS - 2;
  // NAPOT readback forces the low G-1 bits to 1; OFF/TOR readback clears the low G bits.
  localparam logic [63:0] NAPOT_ONES = (64'd1 << (G >= 1 ? G - 1 : 0)) - 64'd1;
  localparam logic [63:0] GRAN_MASK  = (64'd1 << G) - 64'd1;

  logic       locked;
  logic [7:0] cfg_legal;

  assign locked = cfg[7];

  always_comb begin
    cfg_legal      = cfg_wdata;
    cfg_legal[6:5] = 2'b00;
    if (!cfg_wdata[0]) cfg_legal[1] = 1'b0;
    // NA4 cannot be represented when the granule exceeds 4 bytes; keep the old mode.
    if ((G >= 1) && (cfg_wdata[4:3] == 2'b10)) cfg_legal[4:3] = cfg[4:3];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cfg <= '0;
      adr <= '0;
    end else begin
      if (cfg_we && !locked) cfg <= cfg_legal;
      if (adr_we && !locked && !next_tor_lock) adr <= adr_wdata;
    end
  end

  always_comb begin
    adr_rd = adr;
    if (cfg[4:3] == 2'b11) adr_rd = adr | NAPOT_ONES[AW-1:0];
    else if (!cfg[4])      adr_rd = adr & ~GRAN_MASK[AW-1:0];
  end
endmodule

module pmp_csr_regs #(
  parameter int XLEN        = 64,
  parameter int PA_BITS     = 56,
  parameter int PMP_ENTRIES = 16,
  parameter int G           = 0
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                CSRWriteM,
  input  logic                                CSRReadM,
  input  logic [11:0]                         CSRAdrM,
  input  logic [XLEN-1:0]                     CSRWriteValM,
  output logic [XLEN-1:0]                     CSRReadValM,
  output logic                                ReadValid,
  output logic                                WriteAck,
  output logic                                IllegalCSR,
  output logic [8*PMP_ENTRIES-1:0]            PMPCfg,
  output logic [(PA_BITS-2)*PMP_ENTRIES-1:0]  PMPAdr
);
  localparam int AW  = PA_BITS - 2;
  localparam int NE  = (PMP_ENTRIES > 0) ? PMP_ENTRIES : 1;
  localparam int BPR = XLEN / 8;

  logic [NE-1:0][7:0]    cfg_q;
  logic [NE-1:0][AW-1:0] adr_q;
  logic [NE-1:0][AW-1:0] adr_rd;

  logic            is_cfg, is_adr, illegal, hit;
  logic [3:0]      cfg_grp;
  logic [11:0]     adr_off;
  logic [XLEN-1:0] rdata;

  assign is_cfg  = (CSRAdrM[11:4] == 8'h3A);
  assign is_adr  = (CSRAdrM >= 12'h3B0) && (CSRAdrM <= 12'h3EF);
  // On RV64 only the even pmpcfg registers exist.
  assign illegal = is_cfg && (XLEN == 64) && CSRAdrM[0];
  assign hit     = (is_cfg | is_adr) & ~illegal;
  assign adr_off = CSRAdrM - 12'h3B0;
  assign cfg_grp = (XLEN == 64) ? {1'b0, CSRAdrM[3:1]} : CSRAdrM[3:0];

  genvar i;
  generate
    for (i = 0; i < NE; i++) begin : g_ent
      if (i < PMP_ENTRIES) begin : g_impl
        logic tor_lock;
        if (i + 1 < PMP_ENTRIES) begin : g_nxt
          assign tor_lock = cfg_q[i+1][7] & (cfg_q[i+1][4:3] == 2'b01);
        end else begin : g_last
          assign tor_lock = 1'b0;
        end

        pmp_entry #(.PA_BITS(PA_BITS), .G(G)) u_ent (
          .clk           (clk),
          .reset         (reset),
          .cfg_we        (CSRWriteM & hit & is_cfg & (cfg_grp == 4'(i / BPR))),
          .cfg_wdata     (CSRWriteValM[8*(i%BPR) +: 8]),
          .adr_we        (CSRWriteM & hit & is_adr & (adr_off == 12'(i))),
          .adr_wdata     (AW'(CSRWriteValM)),
          .next_tor_lock (tor_lock),
          .cfg           (cfg_q[i]),
          .adr           (adr_q[i]),
          .adr_rd        (adr_rd[i])
        );
      end else begin : g_absent
        assign cfg_q[i]  = '0;
        assign adr_q[i]  = '0;
        assign adr_rd[i] = '0;
      end
    end

    if (PMP_ENTRIES > 0) begin : g_out
      assign PMPCfg = cfg_q;
      assign PMPAdr = adr_q;
    end else begin : g_none
      assign PMPCfg = '0;
      assign PMPAdr = '0;
    end
  endgenerate

  // Read mux sees pre-write state, so a same-cycle read+write returns the old value.
  always_comb begin
    rdata = '0;
    for (int e = 0; e < PMP_ENTRIES; e++) begin
      if (is_cfg && (cfg_grp == 4'(e / BPR))) rdata[8*(e%BPR) +: 8] = cfg_q[e];
      if (is_adr && (adr_off == 12'(e)))      rdata = XLEN'(adr_rd[e]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      CSRReadValM <= '0;
      ReadValid   <= 1'b0;
      WriteAck    <= 1'b0;
      IllegalCSR  <= 1'b0;
    end else begin
      ReadValid  <= CSRReadM & hit;
      WriteAck   <= CSRWriteM & hit;
      IllegalCSR <= (CSRReadM | CSRWriteM) & illegal;
      if (CSRReadM & hit) CSRReadValM <= rdata;
    end
  end
endmodule

// File: tb/tb_pmp_csr_regs.sv
// Scoreboard bench: drives one CSR access per cycle into a G=0 and a G=2 instance and
// checks pulses, read data and exported entry values against bench-computed expectations.

module tb_pmp_csr_regs;
  localparam int XLEN = 64, PA_BITS = 56, NENT = 16, AW = PA_BITS - 2;
  localparam logic [63:0] ONES54 = 64'h003F_FFFF_FFFF_FFFF;

  logic              clk = 1'b0, reset = 1'b1;
  logic              CSRWriteM = 1'b0, CSRReadM = 1'b0;
  logic [11:0]       CSRAdrM = '0;
  logic [XLEN-1:0]   CSRWriteValM = '0;
  logic [XLEN-1:0]   rdv0, rdv2;
  logic              rv0, wa0, il0, rv2, wa2, il2;
  logic [8*NENT-1:0] cfg0, cfg2;
  logic [AW*NENT-1:0] adr0, adr2;

  always #5 clk = ~clk;

  pmp_csr_regs #(.XLEN(XLEN), .PA_BITS(PA_BITS), .PMP_ENTRIES(NENT), .G(0)) u_dut0 (
    .clk(clk), .reset(reset), .CSRWriteM(CSRWriteM), .CSRReadM(CSRReadM),
    .CSRAdrM(CSRAdrM), .CSRWriteValM(CSRWriteValM), .CSRReadValM(rdv0),
    .ReadValid(rv0), .WriteAck(wa0), .IllegalCSR(il0), .PMPCfg(cfg0), .PMPAdr(adr0));

  pmp_csr_regs #(.XLEN(XLEN), .PA_BITS(PA_BITS), .PMP_ENTRIES(NENT), .G(2)) u_dut2 (
    .clk(clk), .reset(reset), .CSRWriteM(CSRWriteM), .CSRReadM(CSRReadM),
    .CSRAdrM(CSRAdrM), .CSRWriteValM(CSRWriteValM), .CSRReadValM(rdv2),
    .ReadValid(rv2), .WriteAck(wa2), .IllegalCSR(il2), .PMPCfg(cfg2), .PMPAdr(adr2));

  typedef struct {
    string       tag;
    logic [2:0]  fl;   // {ReadValid, WriteAck, IllegalCSR}
    logic [63:0] e0;
    logic [63:0] e2;
  } item_t;

  item_t       sb[$];
  item_t       mon_it;
  logic [63:0] last0 = '0, last2 = '0;
  int          n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Responses for the access driven at the previous negedge appear after this edge.
  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      mon_it = sb.pop_front();
      if (mon_it.fl[2]) begin
        last0 = mon_it.e0;
        last2 = mon_it.e2;
      end
      chk({mon_it.tag, "/flags_g0"}, {61'd0, rv0, wa0, il0}, {61'd0, mon_it.fl});
      chk({mon_it.tag, "/flags_g2"}, {61'd0, rv2, wa2, il2}, {61'd0, mon_it.fl});
      chk({mon_it.tag, "/rdata_g0"}, rdv0, last0);
      chk({mon_it.tag, "/rdata_g2"}, rdv2, last2);
    end
  end

  task automatic acc(input logic rd, input logic wr, input logic [11:0] a,
                     input logic [63:0] v, input logic [2:0] fl,
                     input logic [63:0] e0, input logic [63:0] e2, input string tag);
    item_t it;
    @(negedge clk);
    CSRReadM = rd; CSRWriteM = wr; CSRAdrM = a; CSRWriteValM = v;
    it.tag = tag; it.fl = fl; it.e0 = e0; it.e2 = e2;
    sb.push_back(it);
  endtask

  task automatic rd(input logic [11:0] a, input logic [63:0] e0, input logic [63:0] e2,
                    input string tag);
    acc(1'b1, 1'b0, a, 64'd0, 3'b100, e0, e2, tag);
  endtask

  task automatic wr(input logic [11:0] a, input logic [63:0] v, input string tag);
    acc(1'b0, 1'b1, a, v, 3'b010, 64'd0, 64'd0, tag);
  endtask

  task automatic idle();
    acc(1'b0, 1'b0, 12'h000, 64'd0, 3'b000, 64'd0, 64'd0, "idle");
  endtask

  // Reset is held with a write pending to show reset wins over it.
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; CSRWriteM = 1'b1; CSRReadM = 1'b1;
    CSRAdrM = 12'h3B1; CSRWriteValM = 64'h44;
    repeat (2) @(negedge clk);
    chk("rst/flags", {58'd0, rv0, wa0, il0, rv2, wa2, il2}, 64'd0);
    chk("rst/rdata", rdv0 | rdv2, 64'd0);
    chk("rst/pmpcfg", {63'd0, (|cfg0) | (|cfg2)}, 64'd0);
    chk("rst/pmpadr", {63'd0, (|adr0) | (|adr2)}, 64'd0);
    reset = 1'b0; CSRWriteM = 1'b0; CSRReadM = 1'b0;
    last0 = '0; last2 = '0;
  endtask

  initial begin
    do_reset();
    rd(12'h3A0, 64'h0, 64'h0, "rst_cfg0");
    idle();
    rd(12'h3B0, 64'h0, 64'h0, "rst_adr0");
    idle();

    wr(12'h3A0, 64'h0F, "cfg0_tor");
    idle();
    chk("pmpcfg_e0_g0", cfg0[7:0], 64'h0F);
    chk("pmpcfg_e0_g2", cfg2[7:0], 64'h0F);
    wr(12'h3B0, 64'h1000, "adr0_wr");
    idle();
    chk("pmpadr_e0_g0", adr0[AW-1:0], 64'h1000);
    chk("pmpadr_e0_g2", adr2[AW-1:0], 64'h1000);
    rd(12'h3B0, 64'h1000, 64'h1000, "adr0_rb");
    rd(12'h3A0, 64'h0F, 64'h0F, "cfg0_rb");
    wr(12'h3A0, 64'h6702, "cfg0_legal");
    rd(12'h3A0, 64'h0700, 64'h0700, "cfg0_legal_rb");

    // Granularity: NAPOT ones, NA4 refused at G=2, TOR masking
    wr(12'h3A0, 64'h19, "cfg0_napot");
    wr(12'h3B0, 64'h0, "adr0_zero");
    rd(12'h3B0, 64'h0, 64'h1, "napot_rb");
    wr(12'h3A0, 64'h11, "cfg0_na4");
    rd(12'h3A0, 64'h11, 64'h19, "na4_rb");
    rd(12'h3B0, 64'h0, 64'h1, "napot_keep");
    wr(12'h3A0, 64'h09, "cfg0_tor2");
    wr(12'h3B0, 64'h7, "adr0_7");
    rd(12'h3B0, 64'h7, 64'h4, "tor_mask");
    idle();
    chk("pmpadr_unmasked_g0", adr0[AW-1:0], 64'h7);
    chk("pmpadr_unmasked_g2", adr2[AW-1:0], 64'h7);
    wr(12'h3B1, 64'hFFFF_FFFF_FFFF_FFFF, "adr1_wide");
    rd(12'h3B1, ONES54, ONES54 & ~64'h3, "adr1_trunc");

    // Same-cycle read and write
    wr(12'h3B3, 64'h5, "adr3_old");
    acc(1'b1, 1'b1, 12'h3B3, 64'h9, 3'b110, 64'h5, 64'h4, "adr3_rw");
    rd(12'h3B3, 64'h9, 64'h8, "adr3_new");

    // Lock entry1 as TOR: guards pmpaddr0, pmpaddr1 and cfg byte1
    wr(12'h3A0, 64'h8F09, "lock_e1");
    wr(12'h3B0, 64'h2222, "torlock_adr0");
    wr(12'h3B1, 64'h3333, "lock_adr1");
    wr(12'h3A0, 64'h0B, "lock_cfg_b1");
    rd(12'h3A0, 64'h8F0B, 64'h8F0B, "lock_cfg_rb");
    rd(12'h3B0, 64'h7, 64'h4, "torlock_rb");
    rd(12'h3B1, ONES54, ONES54 & ~64'h3, "lock_adr1_rb");
    wr(12'h3B2, 64'hABD, "adr2_free");
    rd(12'h3B2, 64'hABD, 64'hABC, "adr2_rb");
    idle();
    chk("pmpcfg_e1_lock", cfg0[15:8], 64'h8F);
    chk("pmpadr_e1_lock", adr0[2*AW-1:AW], ONES54);

    // Illegal odd pmpcfg, wider pmpcfg map, unimplemented entries, undecoded address
    acc(1'b1, 1'b0, 12'h3A1, 64'h0, 3'b001, 64'h0, 64'h0, "odd_rd");
    acc(1'b0, 1'b1, 12'h3A1, 64'hFF, 3'b001, 64'h0, 64'h0, "odd_wr");
    rd(12'h3A0, 64'h8F0B, 64'h8F0B, "odd_nochg");
    wr(12'h3A2, 64'h0100, "cfg2_wr");
    rd(12'h3A2, 64'h0100, 64'h0100, "cfg2_rb");
    idle();
    chk("pmpcfg_e9", cfg0[79:72], 64'h01);
    wr(12'h3C4, 64'h55, "adr20_wr");
    rd(12'h3C4, 64'h0, 64'h0, "adr20_rb");
    wr(12'h3A4, 64'hFFFF_FFFF_FFFF_FFFF, "cfg4_wr");
    rd(12'h3A4, 64'h0, 64'h0, "cfg4_rb");
    wr(12'h3BF, 64'h123, "adr15_wr");
    rd(12'h3BF, 64'h123, 64'h120, "adr15_rb");
    acc(1'b1, 1'b1, 12'h300, 64'h1, 3'b000, 64'h0, 64'h0, "undecoded");
    idle();

    // Reset clears the lock
    do_reset();
    wr(12'h3B1, 64'h44, "post_rst_adr1");
    rd(12'h3B1, 64'h44, 64'h44, "post_rst_rb");
    idle();
    @(posedge clk);
    #2;
    chk("drain", 64'(sb.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
